// File: rtl/signal_debounce.sv
// Two-flop synchronizer followed by a four-state debounce FSM that qualifies a
// new level only after it has held for DEBOUNCE_CYCLES consecutive clocks.
module signal_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
            $error("signal_debounce: DEBOUNCE_CYCLES must be >= 2");
        end
        if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_width
            $error("signal_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } state_t;

    logic             sync0;
    logic             sync1;
    logic             s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             q_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             busy_nxt;

    // Stage: metastability synchronizer, raw is never sampled elsewhere
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
        end
    end

    assign s = sync1;

    // Stage: qualification FSM; a reversal during PEND drops all progress
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            STABLE_LOW: begin
                if (s) begin
                    state_nxt = PEND_HIGH;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            PEND_HIGH: begin
                if (!s) begin
                    state_nxt = STABLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_HIGH;
                    cnt_nxt   = '0;
                    q_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_nxt = PEND_LOW;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            PEND_LOW: begin
                if (s) begin
                    state_nxt = STABLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_LOW;
                    cnt_nxt   = '0;
                    q_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = STABLE_LOW;
                cnt_nxt   = '0;
                q_nxt     = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt == PEND_HIGH) || (state_nxt == PEND_LOW);
    end

    // Stage: registered state and outputs, busy tracks the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            q     <= q_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule
